modmul_ctrl: RTL and testbench

MODMUL_CTRL -- requirements
Module: modmul_ctrl

---
 rtl/modmul_if.sv | 20 ++
 rtl/modmul_ctrl.sv | 122 ++++++++++++
 tb/tb_modmul_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/modmul_if.sv
// rtl/modmul_if.sv - serial link between the modmul controller and the multiplier
interface modmul_if #(
   parameter int LEN = 22
);
   logic           mm_a;
   logic [LEN-1:0] mm_b;
   logic           mm_isync;
   logic           mm_q;
   logic           mm_osync;

   modport master (
      output mm_a, mm_b, mm_isync,
      input  mm_q, mm_osync
   );

   modport slave (
      input  mm_a, mm_b, mm_isync,
      output mm_q, mm_osync
   );
endinterface

// File: rtl/modmul_ctrl.sv
// rtl/modmul_ctrl.sv - serialises A to a bit-serial modular multiplier and deserialises its product
module modmul_ctrl #(
   parameter int LEN     = 22,
   parameter int TIMEOUT = 256
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [LEN-1:0]  a_in,
   input  logic [LEN-1:0]  b_in,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [LEN-1:0]  result,
   modmul_if.master        mm
);
   localparam int CW = $clog2(LEN + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] BIT_LAST = CW'(LEN - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, SHIFT, WAIT, CAPT, FIN} state_t;

   state_t         state, state_n;
   logic [LEN-1:0] a_sr;
   logic [LEN-1:0] b_reg;
   logic [LEN-1:0] cap_sr;
   logic [CW-1:0]  bcnt;
   logic [TW-1:0]  tcnt;
   logic           done_n;
   logic           err_n;

   // Outputs to the multiplier; outside SHIFT the serial line pads with zeros
   assign mm.mm_a     = (state == SHIFT) & a_sr[0];
   assign mm.mm_isync = (state == SHIFT) && (bcnt == '0);
   assign mm.mm_b     = b_reg;
   assign busy        = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state and completion pulses; timeout only applies until osync is seen
   always_comb begin
      state_n = state;
      done_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_n = SHIFT;
         end
         SHIFT, WAIT: begin
            if (mm.mm_osync) begin
               state_n = CAPT;
            end else if (tcnt == TO_LAST) begin
               state_n = IDLE;
               err_n   = 1'b1;
            end else if (state == SHIFT && bcnt == BIT_LAST) begin
               state_n = WAIT;
            end
         end
         CAPT: begin
            if (bcnt == BIT_LAST) state_n = FIN;
         end
         FIN: begin
            state_n = IDLE;
            done_n  = 1'b1;
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath: operand capture, A shift-out, counters, product shift-in, result load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_sr   <= '0;
         b_reg  <= '0;
         cap_sr <= '0;
         bcnt   <= '0;
         tcnt   <= '0;
         result <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= done_n;
         err  <= err_n;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a_in;
                  b_reg <= b_in;
                  bcnt  <= '0;
                  tcnt  <= '0;
               end
            end
            SHIFT, WAIT: begin
               if (state == SHIFT) begin
                  a_sr <= a_sr >> 1;
                  bcnt <= bcnt + CW'(1);
               end
               if (mm.mm_osync) begin
                  // product bit 0 arrives with osync; bcnt now counts captured bits
                  cap_sr <= {mm.mm_q, cap_sr[LEN-1:1]};
                  bcnt   <= CW'(1);
               end else if (tcnt != TO_LAST) begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            CAPT: begin
               cap_sr <= {mm.mm_q, cap_sr[LEN-1:1]};
               if (bcnt != BIT_LAST) bcnt <= bcnt + CW'(1);
            end
            FIN: begin
               result <= cap_sr;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_modmul_ctrl.sv
// tb/tb_modmul_ctrl.sv - scoreboard bench for modmul_ctrl with a behavioural serial multiplier
module tb_modmul_ctrl;
   localparam int LEN = 22;
   localparam longint unsigned P = (64'd1 << LEN) - 64'd3;

   typedef struct {
      bit             is_err;
      logic [LEN-1:0] val;
   } exp_t;

   logic           clk;
   logic           reset;
   logic           start;
   logic [LEN-1:0] a_in;
   logic [LEN-1:0] b_in;
   logic           busy;
   logic           done;
   logic           err;
   logic [LEN-1:0] result;

   modmul_if #(.LEN(LEN)) mif ();

   modmul_ctrl #(.LEN(LEN), .TIMEOUT(256)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a_in   (a_in),
      .b_in   (b_in),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result),
      .mm     (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   logic [LEN-1:0] last_res = '0;
   int   model_lat  = LEN + 2;
   bit   model_mute = 1'b0;

   function automatic longint unsigned mulmod(longint unsigned a, longint unsigned b);
      return (a * b) % P;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Multiplier model: gathers LEN serial A bits after isync, replies model_lat cycles after isync
   int             col_k   = -1;
   int             out_cnt = -1;
   int             out_idx = -1;
   logic [LEN-1:0] a_acc, b_cap, r_val;
   initial begin
      mif.mm_q     = 1'b0;
      mif.mm_osync = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         mif.mm_q     = 1'b0;
         mif.mm_osync = 1'b0;
         if (!reset) begin
            col_k   = -1;
            out_cnt = -1;
            out_idx = -1;
         end else begin
            if (mif.mm_isync) begin
               col_k   = 0;
               a_acc   = '0;
               b_cap   = mif.mm_b;
               out_cnt = model_lat;
            end else if (col_k < 0) begin
               check("mm_a_pad", mif.mm_a, 0);
            end
            if (col_k >= 0) begin
               a_acc[col_k] = mif.mm_a;
               col_k++;
               if (col_k == LEN) begin
                  col_k = -1;
                  r_val = LEN'(mulmod(a_acc, b_cap));
               end
            end
            if (out_cnt == 0 && !model_mute) out_idx = 0;
            if (out_cnt >= 0) out_cnt--;
            if (out_idx >= 0) begin
               mif.mm_q     = r_val[out_idx];
               mif.mm_osync = (out_idx == 0);
               out_idx++;
               if (out_idx == LEN) out_idx = -1;
            end
         end
      end
   end

   // Monitor: every done/err pulse is matched against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (reset && (done || err)) begin
         check("done_err_excl", done & err, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {done, err}, 0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind", err, e.is_err);
            check("result", result, e.val);
         end
      end
   end

   task automatic issue(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
      exp_t e;
      a_in  = a;
      b_in  = b;
      start = 1'b1;
      e.is_err = 1'b0;
      e.val    = LEN'(mulmod(a, b));
      last_res = e.val;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      bit got = 0;
      for (int i = 0; i < lim && !got; i++) begin
         @(negedge clk);
         if (done || err) got = 1;
      end
      if (!got) check("wait_done_timeout", 0, 1);
   endtask

   int             cnt;
   int             isyncs;
   bit             got;
   logic [LEN-1:0] abits;
   int             gap0, gap1, g;
   logic [LEN-1:0] ra, rb;
   exp_t           te;

   initial begin
      reset = 1'b0;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_result", result, 0);
      check("rst_mm_a", mif.mm_a, 0);
      check("rst_isync", mif.mm_isync, 0);
      check("rst_mm_b", mif.mm_b, 0);
      reset = 1'b1;
      @(negedge clk);

      // 2*3: serial pattern, single isync, latency, busy falls with done
      model_lat = LEN + 2;
      a_in = 2; b_in = 3; start = 1'b1;
      te.is_err = 0; te.val = 6; last_res = 6; exp_q.push_back(te);
      cnt = 0; isyncs = 0; abits = '0; got = 0;
      for (int j = 0; j < 200 && !got; j++) begin
         @(negedge clk);
         start = 1'b0;
         cnt++;
         if (mif.mm_isync) isyncs++;
         if (cnt == 1) check("mm_b_held", mif.mm_b, 3);
         if (cnt - 1 < LEN) abits[cnt-1] = mif.mm_a;
         if (done) begin
            got = 1;
            check("busy_at_done", busy, 0);
         end
      end
      check("t1_done_seen", got, 1);
      check("t1_latency", cnt - 1, model_lat + LEN + 1);
      check("t1_mm_a_bits", abits, 2);
      check("t1_isync_count", isyncs, 1);

      // boundary operands
      @(negedge clk);
      issue(LEN'(4194300), LEN'(4194300));
      wait_done(400);
      @(negedge clk);
      issue('0, LEN'(12345));
      wait_done(400);
      @(negedge clk);

      // start re-asserted 5 cycles into SHIFT must be ignored
      issue(LEN'(1000), LEN'(777));
      repeat (5) @(negedge clk);
      a_in = LEN'(55); b_in = LEN'(66); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(400);
      repeat (100) @(negedge clk);
      check("t3_q_empty", exp_q.size(), 0);

      // timeout: multiplier never answers
      model_mute = 1'b1;
      a_in = LEN'(9); b_in = LEN'(9); start = 1'b1;
      te.is_err = 1; te.val = last_res; exp_q.push_back(te);
      cnt = 0; got = 0;
      for (int j = 0; j < 400 && !got; j++) begin
         @(negedge clk);
         start = 1'b0;
         cnt++;
         if (done) check("t4_no_done", done, 0);
         if (err) got = 1;
      end
      check("t4_err_seen", got, 1);
      check("t4_err_cycle", cnt - 1, 256);
      model_mute = 1'b0;
      @(negedge clk);
      check("t4_idle_busy", busy, 0);

      // reset in the middle of CAPT
      model_lat = LEN + 2;
      issue(LEN'(123456), LEN'(654321));
      repeat (30) @(negedge clk);
      reset = 1'b0;
      #1;
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_err", err, 0);
      check("t5_result", result, 0);
      check("t5_mm_a", mif.mm_a, 0);
      check("t5_isync", mif.mm_isync, 0);
      check("t5_mm_b", mif.mm_b, 0);
      exp_q.delete();
      last_res = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (80) @(negedge clk);
      issue(LEN'(31337), LEN'(271828));
      wait_done(400);

      // random operands, random multiplier latency, done-to-start gap 0 or 1
      gap0 = 0; gap1 = 0;
      for (int i = 0; i < 1000; i++) begin
         g = $urandom_range(0, 1);
         if (g == 0) gap0++; else gap1++;
         repeat (g) @(negedge clk);
         model_lat = $urandom_range(LEN, LEN + 8);
         ra = LEN'($urandom_range(0, (1 << LEN) - 1));
         rb = LEN'($urandom_range(0, (1 << LEN) - 1));
         issue(ra, rb);
         wait_done(400);
      end
      check("gap0_exercised", gap0 > 0, 1);
      check("gap1_exercised", gap1 > 0, 1);

      repeat (60) @(negedge clk);
      check("final_q_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
